// File: rtl/hough_pkg.sv
// Shared types and defaults for the Hough peak scanner: accumulator geometry,
// line record layout and scan FSM encoding.
package hough_pkg;

  localparam int unsigned DEF_NUM_RHO   = 1024;
  localparam int unsigned DEF_NUM_THETA = 180;
  localparam int unsigned ACC_AW        = 18;
  localparam int unsigned VOTE_W        = 32;
  localparam int unsigned REC_RHO_W     = 10;
  localparam int unsigned REC_THETA_W   = 8;

  typedef struct packed {
    logic [REC_RHO_W-1:0]   rho;
    logic [REC_THETA_W-1:0] theta;
    logic [VOTE_W-1:0]      votes;
  } line_rec_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    FLUSH,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/hough_line_fifo.sv
// First-word-fall-through FIFO of line records; head is valid whenever !empty.
// DEPTH must be a power of two, >= 2.
module hough_line_fifo
  import hough_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  line_rec_t               push_rec,
  input  logic                    pop,
  output line_rec_t               head,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  line_rec_t        mem_q [DEPTH];
  line_rec_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    // A push on a full FIFO is only accepted when the head leaves in the same cycle.
    do_push  = push && ((cnt_q != (PTR_W+1)'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_rec;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/hough_peak_scanner.sv
// Linear scan of the Hough accumulator, emitting cells with votes >= threshold.
// HOUGH_PEAK_CLEAR_EN: each cell is read then written to zero (2 cycles/cell).
module hough_peak_scanner
  import hough_pkg::*;
#(
  parameter int unsigned NUM_RHO    = DEF_NUM_RHO,
  parameter int unsigned NUM_THETA  = DEF_NUM_THETA,
  parameter int unsigned RHO_W      = REC_RHO_W,
  parameter int unsigned THETA_W    = REC_THETA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [VOTE_W-1:0]   threshold,
  output logic                busy,
  output logic                done,
  output logic [15:0]         lines_found,
  output logic [ACC_AW-1:0]   acc_addr_o,
  input  logic [VOTE_W-1:0]   acc_data_i,
  output logic [VOTE_W-1:0]   acc_data_o,
  output logic [3:0]          acc_we_o,
  output logic                line_valid,
  input  logic                line_ready,
  output logic [RHO_W-1:0]    line_rho,
  output logic [THETA_W-1:0]  line_theta,
  output logic [VOTE_W-1:0]   line_votes
);

  // RHO_W/THETA_W must not exceed the record field widths in hough_pkg.
  localparam int unsigned          CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [RHO_W-1:0]     LAST_RHO   = RHO_W'(NUM_RHO - 1);
  localparam logic [THETA_W-1:0]   LAST_THETA = THETA_W'(NUM_THETA - 1);

  scan_state_t         state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         lines_q, lines_d;
  logic [VOTE_W-1:0]   thr_q, thr_d;
  logic [RHO_W-1:0]    rho_q, rho_d, tag_rho_q, tag_rho_d;
  logic [THETA_W-1:0]  theta_q, theta_d, tag_theta_q, tag_theta_d;
  logic [ACC_AW-1:0]   addr_q, addr_d;
  logic                rd_vld_q, rd_vld_d;
`ifdef HOUGH_PEAK_CLEAR_EN
  logic                wr_ph_q, wr_ph_d;
`endif

  logic                room, last_cell, push, pop, advance, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  line_rec_t           push_rec, head;

  // Counting the in-flight read keeps the FIFO from ever being pushed while full.
  assign room      = (32'(fifo_count) + 32'(rd_vld_q)) < FIFO_DEPTH;
  assign last_cell = (rho_q == LAST_RHO) && (theta_q == LAST_THETA);
  assign push      = rd_vld_q && (acc_data_i >= thr_q);
  assign pop       = line_valid && line_ready;
  assign push_rec  = '{rho:   REC_RHO_W'(tag_rho_q),
                       theta: REC_THETA_W'(tag_theta_q),
                       votes: acc_data_i};

  hough_line_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_rec (push_rec),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    lines_d     = lines_q;
    thr_d       = thr_q;
    rho_d       = rho_q;
    theta_d     = theta_q;
    addr_d      = addr_q;
    rd_vld_d    = 1'b0;
    tag_rho_d   = tag_rho_q;
    tag_theta_d = tag_theta_q;
    advance     = 1'b0;
`ifdef HOUGH_PEAK_CLEAR_EN
    wr_ph_d     = wr_ph_q;
`endif

    if (push && (lines_q != 16'hFFFF)) begin
      lines_d = lines_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          busy_d  = 1'b1;
          thr_d   = threshold;
          lines_d = '0;
          rho_d   = '0;
          theta_d = '0;
          addr_d  = '0;
        end
      end
      SCAN: begin
`ifdef HOUGH_PEAK_CLEAR_EN
        if (wr_ph_q) begin
          wr_ph_d = 1'b0;
          advance = 1'b1;
        end else if (room) begin
          rd_vld_d    = 1'b1;
          tag_rho_d   = rho_q;
          tag_theta_d = theta_q;
          wr_ph_d     = 1'b1;
        end
`else
        if (room) begin
          rd_vld_d    = 1'b1;
          tag_rho_d   = rho_q;
          tag_theta_d = theta_q;
          advance     = 1'b1;
        end
`endif
      end
      FLUSH: begin
        if (!rd_vld_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (advance) begin
      if (last_cell) begin
        state_d = FLUSH;
      end else if (rho_q == LAST_RHO) begin
        rho_d   = '0;
        theta_d = theta_q + THETA_W'(1);
        addr_d  = addr_q + ACC_AW'(1);
      end else begin
        rho_d   = rho_q + RHO_W'(1);
        addr_d  = addr_q + ACC_AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lines_q     <= '0;
      thr_q       <= '0;
      rho_q       <= '0;
      theta_q     <= '0;
      addr_q      <= '0;
      rd_vld_q    <= 1'b0;
      tag_rho_q   <= '0;
      tag_theta_q <= '0;
`ifdef HOUGH_PEAK_CLEAR_EN
      wr_ph_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lines_q     <= lines_d;
      thr_q       <= thr_d;
      rho_q       <= rho_d;
      theta_q     <= theta_d;
      addr_q      <= addr_d;
      rd_vld_q    <= rd_vld_d;
      tag_rho_q   <= tag_rho_d;
      tag_theta_q <= tag_theta_d;
`ifdef HOUGH_PEAK_CLEAR_EN
      wr_ph_q     <= wr_ph_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign lines_found = lines_q;
  assign acc_addr_o  = addr_q;
  assign acc_data_o  = '0;
`ifdef HOUGH_PEAK_CLEAR_EN
  assign acc_we_o    = {4{wr_ph_q}};
`else
  assign acc_we_o    = '0;
`endif
  assign line_valid  = !fifo_empty;
  assign line_rho    = line_valid ? head.rho[RHO_W-1:0]     : '0;
  assign line_theta  = line_valid ? head.theta[THETA_W-1:0] : '0;
  assign line_votes  = line_valid ? head.votes              : '0;

endmodule

// File: tb/tb_hough_peak_scanner.sv
// Self-checking bench for hough_peak_scanner on an 8x4 accumulator with a
// 1-cycle-latency BRAM model and a record scoreboard.
`timescale 1ns/1ps
module tb_hough_peak_scanner;
  import hough_pkg::*;

  localparam int NR    = 8;
  localparam int NT    = 4;
  localparam int NCELL = NR * NT;
`ifdef HOUGH_PEAK_CLEAR_EN
  localparam int LAT_MIN = 65;
  localparam int LAT_MAX = 75;
`else
  localparam int LAT_MIN = 33;
  localparam int LAT_MAX = 40;
`endif

  typedef struct packed {
    logic [9:0]  rho;
    logic [7:0]  theta;
    logic [31:0] votes;
  } exp_t;

  typedef struct {
    int          pat;
    logic [31:0] thr;
    int          rdy;
    int          exp_lines;
    int          restart;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] threshold = '0;
  logic        busy, done, line_valid;
  logic        line_ready = 1'b0;
  logic [15:0] lines_found;
  logic [17:0] acc_addr_o;
  logic [31:0] acc_data_i = '0;
  logic [31:0] acc_data_o, line_votes;
  logic [3:0]  acc_we_o;
  logic [9:0]  line_rho;
  logic [7:0]  line_theta;

  hough_peak_scanner #(
    .NUM_RHO    (NR),
    .NUM_THETA  (NT),
    .RHO_W      (10),
    .THETA_W    (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .threshold   (threshold),
    .busy        (busy),
    .done        (done),
    .lines_found (lines_found),
    .acc_addr_o  (acc_addr_o),
    .acc_data_i  (acc_data_i),
    .acc_data_o  (acc_data_o),
    .acc_we_o    (acc_we_o),
    .line_valid  (line_valid),
    .line_ready  (line_ready),
    .line_rho    (line_rho),
    .line_theta  (line_theta),
    .line_votes  (line_votes)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // BRAM model: read-first, writes tracked per load generation.
  logic [31:0] mem [NCELL];
  int wr_gen [NCELL];
  int wr_cnt [NCELL];
  int gen      = 1;
  int total_wr = 0;
  int bad_wr   = 0;

  always @(posedge clk) begin
    int a;
    a = int'(acc_addr_o);
    if (a < NCELL) begin
      acc_data_i <= (wr_gen[a] == gen) ? 32'd0 : mem[a];
      if (acc_we_o != 4'h0) begin
        total_wr++;
        if (acc_we_o != 4'hF || acc_data_o != 32'd0) bad_wr++;
        if (wr_gen[a] != gen) begin
          wr_gen[a] = gen;
          wr_cnt[a] = 1;
        end else begin
          wr_cnt[a]++;
        end
      end
    end else if (acc_we_o != 4'h0) begin
      bad_wr++;
    end
  end

  int rdy_mode = 0;
  int rcyc     = 0;
  initial forever begin
    @(posedge clk);
    #1;
    rcyc++;
    case (rdy_mode)
      0:       line_ready = 1'b1;
      1:       line_ready = ((rcyc % 4) == 0);
      default: line_ready = 1'($urandom_range(0, 1));
    endcase
  end

  exp_t        exp_q[$];
  int          n_popped = 0;
  bit          prev_stall = 1'b0;
  logic [49:0] prev_rec;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_stable", {line_valid, line_rho, line_theta, line_votes}, {1'b1, prev_rec});
      if (line_valid && line_ready) begin
        n_popped++;
        if (exp_q.size() == 0) begin
          chk("extra_record", {line_rho, line_theta, line_votes}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("record", {line_rho, line_theta, line_votes}, e);
        end
      end
      prev_stall = line_valid && !line_ready;
      prev_rec   = {line_rho, line_theta, line_votes};
    end
  end

  task automatic load_pattern(input int p);
    gen++;
    for (int i = 0; i < NCELL; i++) begin
      case (p)
        0:       mem[i] = (i == 10) ? 32'd50 : 32'd0;
        1:       mem[i] = (i == 0 || i == NCELL - 1) ? 32'd7 : 32'd0;
        2:       mem[i] = 32'd100;
        3:       mem[i] = 32'd0;
        4:       mem[i] = 32'(i * 3);
        default: mem[i] = $urandom;
      endcase
    end
  endtask

  task automatic build_expected(input logic [31:0] thr);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < NCELL; i++) begin
      if (mem[i] >= thr) begin
        e.rho   = 10'(i % NR);
        e.theta = 8'(i / NR);
        e.votes = mem[i];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    bit got;
    int snap_wr, snap_bad, snap_pop, bad;
    load_pattern(v.pat);
    build_expected(v.thr);
    rdy_mode = v.rdy;
    snap_wr  = total_wr;
    snap_bad = bad_wr;
    snap_pop = n_popped;
    @(posedge clk); #1;
    start     = 1'b1;
    threshold = v.thr;
    @(posedge clk); #1;
    start     = 1'b0;
    threshold = ~v.thr;
    chk("busy_after_start", busy, 1);
    chk("lines_cleared", lines_found, 0);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = (v.restart != 0 && cyc == v.restart);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    if (got) begin
      if (v.rdy == 0 && v.restart == 0)
        chk("done_latency_range", (cyc >= LAT_MIN && cyc <= LAT_MAX), 1);
      chk("lines_found", lines_found, v.exp_lines);
      chk("busy_low_at_done", busy, 0);
      chk("all_records_seen", exp_q.size(), 0);
      chk("record_count", n_popped - snap_pop, v.exp_lines);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
    exp_q.delete();
`ifdef HOUGH_PEAK_CLEAR_EN
    bad = 0;
    for (int i = 0; i < NCELL; i++)
      if (wr_gen[i] != gen || wr_cnt[i] != 1) bad++;
    chk("cleared_once", bad, 0);
`else
    bad = total_wr - snap_wr;
    chk("no_writes", bad, 0);
`endif
    chk("write_format", bad_wr - snap_bad, 0);
  endtask

  vec_t vecs[9];
  bit   saw;

  initial begin
    vecs[0] = '{0, 32'd20,          0, 1,  0};
    vecs[1] = '{1, 32'd7,           0, 2,  0};
    vecs[2] = '{2, 32'd1,           1, 32, 0};
    vecs[3] = '{3, 32'hFFFF_FFFF,   0, 0,  0};
    vecs[4] = '{4, 32'd40,          2, 18, 0};
    vecs[5] = '{2, 32'd100,         1, 32, 0};
    vecs[6] = '{2, 32'd101,         0, 0,  0};
    vecs[7] = '{2, 32'd1,           1, 32, 10};
    vecs[8] = '{5, 32'd0,           2, 32, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lines", lines_found, 0);
    chk("rst_addr", acc_addr_o, 0);
    chk("rst_we", acc_we_o, 0);
    chk("rst_wdata", acc_data_o, 0);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_line_fields", {line_rho, line_theta, line_votes}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, done, line_valid}, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a scan.
    load_pattern(2);
    build_expected(32'd1);
    rdy_mode = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    threshold = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    chk("pre_abort_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_lines", lines_found, 0);
    chk("abort_addr", acc_addr_o, 0);
    chk("abort_we", acc_we_o, 0);
    chk("abort_line_valid", line_valid, 0);
    chk("abort_line_fields", {line_rho, line_theta, line_votes}, 0);
    exp_q.delete();
    saw = 1'b0;
    repeat (3) @(negedge clk) if (done) saw = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (60) @(negedge clk) if (done || busy || line_valid) saw = 1'b1;
    chk("abort_no_done", saw, 0);

    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
